// File: rtl/lsu_mem_port_pkg.sv
// Shared processor definitions for the load/store unit: FSM states, default widths
// and the word-offset size used for alignment.
package lsu_mem_port_pkg;

  localparam int unsigned DBITS_DEFAULT    = 32;
  localparam int unsigned REG_BITS_DEFAULT = 4;
  localparam int unsigned WORD_OFFSET_BITS = 2;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsuState_t;

endpackage

// File: rtl/lsu_mem_port.sv
// Load/store unit between execute and writeback: one outstanding word access on a
// req/ack memory port. Optional macro LSU_MISALIGN_TRAP_EN traps unaligned ops.
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int unsigned DBITS    = DBITS_DEFAULT,
  parameter int unsigned REG_BITS = REG_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                exValid,
  input  logic                exIsLoad,
  input  logic                exIsStore,
  input  logic [DBITS-1:0]    exAddr,
  input  logic [DBITS-1:0]    exStoreData,
  input  logic [REG_BITS-1:0] exRegDst,
  output logic                exReady,
  output logic                memReq,
  output logic                memWe,
  output logic [DBITS-1:0]    memAddr,
  output logic [DBITS-1:0]    memWData,
  input  logic                memAck,
  input  logic [DBITS-1:0]    memRData,
  output logic                wbValid,
  output logic [REG_BITS-1:0] wbRegDst,
  output logic [DBITS-1:0]    wbData
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic                misaligned
`endif
);

  localparam logic [DBITS-1:0] ADDR_MASK = ~DBITS'((1 << WORD_OFFSET_BITS) - 1);

  lsuState_t state;
  logic      acceptOp_c;
  logic      offsetBad_c;

  // Both flags set decodes as a load; neither flag means not a memory op.
  assign acceptOp_c = exValid & (exIsLoad | exIsStore);

`ifdef LSU_MISALIGN_TRAP_EN
  assign offsetBad_c = |exAddr[WORD_OFFSET_BITS-1:0];
`else
  assign offsetBad_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LSU_IDLE;
      exReady  <= 1'b1;
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWData <= '0;
      wbValid  <= 1'b0;
      wbRegDst <= '0;
      wbData   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned <= 1'b0;
`endif
    end else begin
      wbValid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned <= 1'b0;
`endif
      case (state)
        LSU_IDLE: begin
          if (acceptOp_c) begin
            if (offsetBad_c) begin
`ifdef LSU_MISALIGN_TRAP_EN
              misaligned <= 1'b1;
`endif
            end else begin
              state    <= LSU_BUSY;
              exReady  <= 1'b0;
              memReq   <= 1'b1;
              memWe    <= exIsStore & ~exIsLoad;
              memAddr  <= exAddr & ADDR_MASK;
              memWData <= exStoreData;
              wbRegDst <= exRegDst;
            end
          end
        end
        // Request held with stable payload until the memory acknowledges it.
        LSU_BUSY: begin
          if (memAck) begin
            memReq <= 1'b0;
            if (memWe) begin
              state   <= LSU_IDLE;
              exReady <= 1'b1;
            end else begin
              state   <= LSU_DONE;
              wbData  <= memRData;
              wbValid <= 1'b1;
            end
          end
        end
        LSU_DONE: begin
          state   <= LSU_IDLE;
          exReady <= 1'b1;
        end
        default: begin
          state   <= LSU_IDLE;
          exReady <= 1'b1;
          memReq  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed table-driven bench for lsu_mem_port; covers both builds of the
// LSU_MISALIGN_TRAP_EN option.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        exValid, exIsLoad, exIsStore;
  logic [31:0] exAddr, exStoreData;
  logic [3:0]  exRegDst;
  logic        exReady, memReq, memWe;
  logic [31:0] memAddr, memWData;
  logic        memAck;
  logic [31:0] memRData;
  logic        wbValid;
  logic [3:0]  wbRegDst;
  logic [31:0] wbData;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  lsu_mem_port #(.DBITS(32), .REG_BITS(4)) dut (
    .clk(clk), .reset(reset),
    .exValid(exValid), .exIsLoad(exIsLoad), .exIsStore(exIsStore),
    .exAddr(exAddr), .exStoreData(exStoreData), .exRegDst(exRegDst),
    .exReady(exReady), .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memWData(memWData),
    .memAck(memAck), .memRData(memRData),
    .wbValid(wbValid), .wbRegDst(wbRegDst), .wbData(wbData)
`ifdef LSU_MISALIGN_TRAP_EN
    , .misaligned(misaligned)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst, v, ld, st;
    logic [31:0] addr, sdata;
    logic [3:0]  rd;
    bit          ack;
    logic [31:0] rdata;
    bit          eRdy, eReq, eWe;
    logic [31:0] eAddr, eWd;
    bit          eWb;
    logic [3:0]  eRd;
    logic [31:0] eData;
    bit          eMis;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];
  int checks = 0;
  int passed = 0;

  function automatic vec_t mk(bit rst, bit v, bit ld, bit st, logic [31:0] addr,
                              logic [31:0] sdata, logic [3:0] rd, bit ack,
                              logic [31:0] rdata, bit rdy, bit req, bit we,
                              logic [31:0] eaddr, logic [31:0] ewd, bit wb,
                              logic [3:0] erd, logic [31:0] ed, bit mis);
    vec_t r;
    r.rst = rst; r.v = v; r.ld = ld; r.st = st; r.addr = addr; r.sdata = sdata;
    r.rd = rd; r.ack = ack; r.rdata = rdata; r.eRdy = rdy; r.eReq = req; r.eWe = we;
    r.eAddr = eaddr; r.eWd = ewd; r.eWb = wb; r.eRd = erd; r.eData = ed; r.eMis = mis;
    return r;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
  endtask

  initial begin
    // rst v ld st addr sdata rd ack rdata | rdy req we eAddr eWd wb eRd eData mis
    // store, acked on the third BUSY cycle
    tbl[0]  = mk(0,1,0,1,32'h100,32'hDEADBEEF,0,0,0, 0,1,1,32'h100,32'hDEADBEEF,0,0,0,0);
    tbl[1]  = mk(0,0,0,0,0,0,0,0,0,                  0,1,1,32'h100,32'hDEADBEEF,0,0,0,0);
    tbl[2]  = mk(0,0,0,0,0,0,0,0,0,                  0,1,1,32'h100,32'hDEADBEEF,0,0,0,0);
    tbl[3]  = mk(0,0,0,0,0,0,0,1,0,                  1,0,0,0,0,0,0,0,0);
    // load, ack in first BUSY cycle, next acceptance 3 cycles later
    tbl[4]  = mk(0,1,1,0,32'h204,0,5,0,0,            0,1,0,32'h204,0,0,0,0,0);
    tbl[5]  = mk(0,0,0,0,0,0,0,1,32'h12345678,       0,0,0,0,0,1,5,32'h12345678,0);
    tbl[6]  = mk(0,0,0,0,0,0,0,0,0,                  1,0,0,0,0,0,0,0,0);
    tbl[7]  = mk(0,1,1,0,32'h008,0,3,0,0,            0,1,0,32'h008,0,0,0,0,0);
    // back-to-back with exValid held: store waits out DONE, load waits out BUSY
    tbl[8]  = mk(0,1,0,1,32'h40,32'h11111111,0,1,32'hCAFEF00D, 0,0,0,0,0,1,3,32'hCAFEF00D,0);
    tbl[9]  = mk(0,1,0,1,32'h40,32'h11111111,0,0,0,  1,0,0,0,0,0,0,0,0);
    tbl[10] = mk(0,1,0,1,32'h40,32'h11111111,0,0,0,  0,1,1,32'h40,32'h11111111,0,0,0,0);
    tbl[11] = mk(0,1,1,0,32'h44,0,7,1,0,             1,0,0,0,0,0,0,0,0);
    tbl[12] = mk(0,1,1,0,32'h44,0,7,0,0,             0,1,0,32'h44,0,0,0,0,0);
    tbl[13] = mk(0,0,0,0,0,0,0,1,32'hA5A5A5A5,       0,0,0,0,0,1,7,32'hA5A5A5A5,0);
    tbl[14] = mk(0,0,0,0,0,0,0,0,0,                  1,0,0,0,0,0,0,0,0);
    // spurious ack, non-memory op, then both flags decode as load
    tbl[15] = mk(0,0,0,0,0,0,0,1,32'hFFFFFFFF,       1,0,0,0,0,0,0,0,0);
    tbl[16] = mk(0,1,0,0,32'h50,0,4,1,32'hFFFFFFFF,  1,0,0,0,0,0,0,0,0);
    tbl[17] = mk(0,1,1,1,32'h80,32'h99,2,0,0,        0,1,0,32'h80,0,0,0,0,0);
    tbl[18] = mk(0,0,0,0,0,0,0,1,32'h0BADCAFE,       0,0,0,0,0,1,2,32'h0BADCAFE,0);
    tbl[19] = mk(0,0,0,0,0,0,0,0,0,                  1,0,0,0,0,0,0,0,0);
    // reset while BUSY, later ack ignored
    tbl[20] = mk(0,1,0,1,32'h300,32'h5,0,0,0,        0,1,1,32'h300,32'h5,0,0,0,0);
    tbl[21] = mk(1,0,0,0,0,0,0,0,0,                  1,0,0,0,0,0,0,0,0);
    tbl[22] = mk(0,0,0,0,0,0,0,1,32'h1,              1,0,0,0,0,0,0,0,0);
    tbl[23] = mk(0,0,0,0,0,0,0,1,32'h2,              1,0,0,0,0,0,0,0,0);
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[24] = mk(0,1,1,0,32'h103,0,1,0,0,            1,0,0,0,0,0,0,0,1);
    tbl[25] = mk(0,0,0,0,0,0,0,1,32'h77,             1,0,0,0,0,0,0,0,0);
    tbl[26] = mk(0,0,0,0,0,0,0,0,0,                  1,0,0,0,0,0,0,0,0);
`else
    tbl[24] = mk(0,1,1,0,32'h103,0,1,0,0,            0,1,0,32'h100,0,0,0,0,0);
    tbl[25] = mk(0,0,0,0,0,0,0,1,32'h77,             0,0,0,0,0,1,1,32'h77,0);
    tbl[26] = mk(0,0,0,0,0,0,0,0,0,                  1,0,0,0,0,0,0,0,0);
`endif

    reset = 1'b1; exValid = 0; exIsLoad = 0; exIsStore = 0;
    exAddr = '0; exStoreData = '0; exRegDst = '0; memAck = 0; memRData = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_exReady", -1, 32'(exReady), 32'h1);
    chk("rst_memReq", -1, 32'(memReq), 32'h0);
    chk("rst_memWe", -1, 32'(memWe), 32'h0);
    chk("rst_memAddr", -1, memAddr, 32'h0);
    chk("rst_memWData", -1, memWData, 32'h0);
    chk("rst_wbValid", -1, 32'(wbValid), 32'h0);
    chk("rst_wbRegDst", -1, 32'(wbRegDst), 32'h0);
    chk("rst_wbData", -1, wbData, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("rst_misaligned", -1, 32'(misaligned), 32'h0);
`endif

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset = tbl[i].rst; exValid = tbl[i].v; exIsLoad = tbl[i].ld; exIsStore = tbl[i].st;
      exAddr = tbl[i].addr; exStoreData = tbl[i].sdata; exRegDst = tbl[i].rd;
      memAck = tbl[i].ack; memRData = tbl[i].rdata;
      @(posedge clk);
      #1;
      chk("exReady", i, 32'(exReady), 32'(tbl[i].eRdy));
      chk("memReq", i, 32'(memReq), 32'(tbl[i].eReq));
      chk("wbValid", i, 32'(wbValid), 32'(tbl[i].eWb));
      if (tbl[i].eReq) begin
        chk("memWe", i, 32'(memWe), 32'(tbl[i].eWe));
        chk("memAddr", i, memAddr, tbl[i].eAddr);
        if (tbl[i].eWe) chk("memWData", i, memWData, tbl[i].eWd);
      end
      if (tbl[i].eWb) begin
        chk("wbRegDst", i, 32'(wbRegDst), 32'(tbl[i].eRd));
        chk("wbData", i, wbData, tbl[i].eData);
      end
`ifdef LSU_MISALIGN_TRAP_EN
      chk("misaligned", i, 32'(misaligned), 32'(tbl[i].eMis));
`endif
    end

    // reset clears the latched address/data registers too
    @(negedge clk);
    exValid = 1; exIsStore = 1; exIsLoad = 0; exAddr = 32'h3C; exStoreData = 32'hABCD; memAck = 0;
    @(posedge clk); #1;
    chk("pre_rst_memAddr", 100, memAddr, 32'h3C);
    @(negedge clk);
    reset = 1; exValid = 0; exIsStore = 0;
    @(posedge clk); #1;
    chk("post_rst_memAddr", 101, memAddr, 32'h0);
    chk("post_rst_memWData", 101, memWData, 32'h0);
    chk("post_rst_exReady", 101, 32'(exReady), 32'h1);
    @(negedge clk);
    reset = 0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
